// File: rtl/oled_iic_slave.sv
`default_nettype none
// ============================================================================
// Module   : oled_iic_slave
// Brief    : Write-only I2C target that decodes SSD1306 control/data bytes
//            onto a parallel strobe interface with open-drain ACK.
// Revision : 1.0
// ============================================================================
module oled_iic_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h3C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       iic_scl,
  input  logic       iic_sda_in,
  output logic       iic_sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_dc,
  output logic       rx_valid,
  output logic       busy,
  output logic       frame_done,
  output logic       rx_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_CTRL     = 3'd3,
    S_CTRL_ACK = 3'd4,
    S_DATA     = 3'd5,
    S_DATA_ACK = 3'd6,
    S_IGNORE   = 3'd7
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;
  logic                   w_scl_rise;
  logic                   w_scl_fall;
  logic                   w_start;
  logic                   w_stop;

  state_t     r_state;
  state_t     w_state_nx;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nx;
  logic       r_pend;
  logic       w_pend_nx;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nx;
  logic [7:0] w_byte;
  logic       r_ack_hold;
  logic       w_ack_hold_nx;
  logic       r_dc;
  logic       w_dc_nx;
  logic       r_co;
  logic       w_co_nx;
  logic       r_ev_byte;
  logic       w_ev_byte;
  logic       r_ev_fd;
  logic       w_ev_fd;
  logic       r_ev_err;
  logic       w_ev_err;
  logic       w_partial;
  logic       w_in_frame;

  logic       r_sda_oe;
  logic [7:0] r_rx_data;
  logic       r_rx_dc;
  logic       r_rx_valid;
  logic       r_busy;
  logic       r_frame_done;
  logic       r_rx_err;

  // Presetting to 1 makes reset look like an idle bus, so no false START/STOP.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], iic_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], iic_sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // SCL must be high on both samples; an SCL edge coinciding with SDA is data.
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  assign w_partial  = ((r_state == S_CTRL) || (r_state == S_DATA)) && (r_cnt != 3'd0);
  assign w_in_frame = (r_state == S_ADDR_ACK) || (r_state == S_CTRL) ||
                      (r_state == S_CTRL_ACK) || (r_state == S_DATA) ||
                      (r_state == S_DATA_ACK);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_pend     <= 1'b0;
      r_shift    <= 8'h00;
      r_ack_hold <= 1'b0;
      r_dc       <= 1'b0;
      r_co       <= 1'b0;
      r_ev_byte  <= 1'b0;
      r_ev_fd    <= 1'b0;
      r_ev_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_pend     <= w_pend_nx;
      r_shift    <= w_shift_nx;
      r_ack_hold <= w_ack_hold_nx;
      r_dc       <= w_dc_nx;
      r_co       <= w_co_nx;
      r_ev_byte  <= w_ev_byte;
      r_ev_fd    <= w_ev_fd;
      r_ev_err   <= w_ev_err;
    end
  end

  // A bit is only counted once its SCL low phase begins, so the SCL rise
  // preceding a STOP or repeated START never registers as a partial byte.
  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_pend_nx     = r_pend;
    w_shift_nx    = r_shift;
    w_ack_hold_nx = r_ack_hold;
    w_dc_nx       = r_dc;
    w_co_nx       = r_co;
    w_ev_byte     = 1'b0;
    w_ev_fd       = 1'b0;
    w_ev_err      = 1'b0;
    w_byte        = {r_shift[6:0], w_sda};
    if (w_start) begin
      w_ev_err      = w_partial;
      w_state_nx    = S_ADDR;
      w_cnt_nx      = 3'd0;
      w_pend_nx     = 1'b0;
      w_ack_hold_nx = 1'b0;
    end else if (w_stop) begin
      w_ev_fd       = w_in_frame;
      w_ev_err      = w_partial;
      w_state_nx    = S_IDLE;
      w_cnt_nx      = 3'd0;
      w_pend_nx     = 1'b0;
      w_ack_hold_nx = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_CTRL, S_DATA: begin
          if (w_scl_rise) begin
            w_shift_nx = w_byte;
            if (r_cnt == 3'd7) begin
              w_cnt_nx  = 3'd0;
              w_pend_nx = 1'b0;
              if (r_state == S_ADDR) begin
                w_state_nx = ((w_byte[7:1] == SLAVE_ADDR) && !w_byte[0]) ? S_ADDR_ACK : S_IGNORE;
              end else if (r_state == S_CTRL) begin
                w_co_nx    = w_byte[7];
                w_dc_nx    = w_byte[6];
                w_state_nx = S_CTRL_ACK;
              end else begin
                w_ev_byte  = 1'b1;
                w_state_nx = S_DATA_ACK;
              end
            end else begin
              w_pend_nx = 1'b1;
            end
          end else if (w_scl_fall && r_pend) begin
            w_cnt_nx  = r_cnt + 3'd1;
            w_pend_nx = 1'b0;
          end
        end
        S_ADDR_ACK, S_CTRL_ACK, S_DATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_hold) begin
              w_ack_hold_nx = 1'b1;
            end else begin
              w_ack_hold_nx = 1'b0;
              if (r_state == S_ADDR_ACK)      w_state_nx = S_CTRL;
              else if (r_state == S_CTRL_ACK) w_state_nx = S_DATA;
              else                            w_state_nx = r_co ? S_CTRL : S_DATA;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sda_oe     <= 1'b0;
      r_rx_data    <= 8'h00;
      r_rx_dc      <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_rx_err     <= 1'b0;
    end else begin
      r_sda_oe     <= r_ack_hold;
      r_rx_valid   <= r_ev_byte;
      r_frame_done <= r_ev_fd;
      r_rx_err     <= r_ev_err;
      r_busy       <= (r_state == S_CTRL) || (r_state == S_CTRL_ACK) ||
                      (r_state == S_DATA) || (r_state == S_DATA_ACK);
      if (r_ev_byte) begin
        r_rx_data <= r_shift;
        r_rx_dc   <= r_dc;
      end
    end
  end

  assign iic_sda_oe = r_sda_oe;
  assign rx_data    = r_rx_data;
  assign rx_dc      = r_rx_dc;
  assign rx_valid   = r_rx_valid;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign rx_err     = r_rx_err;

endmodule
`default_nettype wire

// File: tb/tb_oled_iic_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_oled_iic_slave
// Brief    : Directed I2C master stimulus with a frame-level model of the
//            expected ACKs, payload bytes and frame/error pulses.
// Revision : 1.0
// ============================================================================
module tb_oled_iic_slave;

  localparam int HP = 10;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl   = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_dc;
  logic       rx_valid;
  logic       busy;
  logic       frame_done;
  logic       rx_err;

  int         total   = 0;
  int         bad     = 0;
  int         fd_cnt  = 0;
  int         err_cnt = 0;
  int         exp_fd  = 0;
  int         exp_err = 0;
  logic [8:0] exp_q[$];
  logic [7:0] fb [0:7];

  assign sda_line = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  oled_iic_slave #(
    .SLAVE_ADDR  (7'h3C),
    .SYNC_STAGES (2)
  ) u_dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .iic_scl    (scl),
    .iic_sda_in (sda_line),
    .iic_sda_oe (sda_oe),
    .rx_data    (rx_data),
    .rx_dc      (rx_dc),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .rx_err     (rx_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; cyc(HP);
    scl   = 1'b1; cyc(HP);
    m_sda = 1'b0; cyc(HP);
    scl   = 1'b0; cyc(HP);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; cyc(HP);
    scl   = 1'b1; cyc(HP);
    m_sda = 1'b1; cyc(2*HP);
    check("busy_after_stop", {31'd0, busy}, 32'd0);
  endtask

  task automatic send_bit(input logic b, input logic exp_busy);
    m_sda = b;    cyc(HP/2);
    scl   = 1'b1; cyc(HP/2);
    check("oe_during_data", {31'd0, sda_oe}, 32'd0);
    check("busy_during_bit", {31'd0, busy}, {31'd0, exp_busy});
    cyc(HP/2);
    scl   = 1'b0; cyc(HP/2);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input logic exp_busy);
    for (int i = 7; i >= 0; i--) send_bit(b[i], exp_busy);
    m_sda = 1'b1; cyc(HP/2);
    scl   = 1'b1; cyc(HP/2);
    check("ack", {31'd0, sda_oe}, {31'd0, exp_ack});
    cyc(HP/2);
    scl   = 1'b0; cyc(HP/2);
  endtask

  // Frame-level model: fb[0] is the address, then control/data bytes
  // alternate according to the Co bit of each control byte.
  task automatic frame(input int n, input int pbits, input logic [7:0] pbyte, input logic stop_end);
    logic addr_ok;
    logic want_ctrl;
    logic co;
    logic dc;
    addr_ok   = (fb[0] == 8'h78);
    want_ctrl = 1'b1;
    co        = 1'b0;
    dc        = 1'b0;
    bus_start();
    send_byte(fb[0], addr_ok, 1'b0);
    for (int i = 1; i < n; i++) begin
      if (addr_ok) begin
        if (want_ctrl) begin
          co        = fb[i][7];
          dc        = fb[i][6];
          want_ctrl = 1'b0;
        end else begin
          exp_q.push_back({dc, fb[i]});
          want_ctrl = co;
        end
      end
      send_byte(fb[i], addr_ok, addr_ok);
    end
    for (int k = 0; k < pbits; k++) send_bit(pbyte[7-k], addr_ok);
    if (addr_ok && pbits > 0) exp_err++;
    if (stop_end) begin
      if (addr_ok) exp_fd++;
      bus_stop();
    end
  endtask

  task automatic frame_checks(input string tag);
    check({tag, "_frame_done_count"}, fd_cnt, exp_fd);
    check({tag, "_rx_err_count"}, err_cnt, exp_err);
    check({tag, "_bytes_outstanding"}, exp_q.size(), 0);
  endtask

  initial begin
    fork
      begin : mon
        logic [8:0] ei;
        logic       pv;
        pv = 1'b0;
        forever begin
          @(negedge clk);
          if (rx_valid) begin
            check("rx_valid_one_cycle", {31'd0, pv}, 32'd0);
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL rx_valid_unexpected actual=%0h/%0b required=none", rx_data, rx_dc);
            end else begin
              ei = exp_q.pop_front();
              check("rx_byte", {23'd0, rx_dc, rx_data}, {23'd0, ei});
            end
          end
          if (frame_done) fd_cnt++;
          if (rx_err)     err_cnt++;
          pv = rx_valid;
        end
      end
    join_none

    cyc(5);
    check("rst_oe",         {31'd0, sda_oe},     32'd0);
    check("rst_rx_data",    {24'd0, rx_data},    32'd0);
    check("rst_rx_dc",      {31'd0, rx_dc},      32'd0);
    check("rst_rx_valid",   {31'd0, rx_valid},   32'd0);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_rx_err",     {31'd0, rx_err},     32'd0);
    rst_n = 1'b1;
    cyc(5);

    fb = '{8'h78, 8'h00, 8'hAE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(3, 0, 8'h00, 1'b1);
    frame_checks("single_cmd");
    check("lit_ae_data", {24'd0, rx_data}, 32'h0000_00AE);
    check("lit_ae_dc",   {31'd0, rx_dc},   32'd0);
    check("lit_ae_fd",   fd_cnt,           32'd1);

    fb = '{8'h78, 8'h40, 8'h01, 8'h02, 8'hFF, 8'h00, 8'h00, 8'h00};
    frame(5, 0, 8'h00, 1'b1);
    frame_checks("data_stream");
    check("lit_ff_data", {24'd0, rx_data}, 32'h0000_00FF);
    check("lit_ff_dc",   {31'd0, rx_dc},   32'd1);

    fb = '{8'h7A, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(3, 0, 8'h00, 1'b1);
    frame_checks("wrong_addr");
    check("lit_wrong_addr_hold", {24'd0, rx_data}, 32'h0000_00FF);

    fb = '{8'h78, 8'h80, 8'hA5, 8'hC0, 8'h3C, 8'h00, 8'h00, 8'h00};
    frame(5, 0, 8'h00, 1'b1);
    frame_checks("co_single");
    check("lit_3c_data", {24'd0, rx_data}, 32'h0000_003C);
    check("lit_3c_dc",   {31'd0, rx_dc},   32'd1);

    fb = '{8'h78, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(2, 4, 8'hA0, 1'b1);
    frame_checks("partial_stop");
    check("lit_partial_err", err_cnt, 32'd1);

    fb = '{8'h78, 8'h40, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(3, 3, 8'hE0, 1'b0);
    fb = '{8'h78, 8'h00, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(3, 0, 8'h00, 1'b1);
    frame_checks("restart");
    check("lit_restart_err", err_cnt, 32'd2);

    fb = '{8'h79, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(2, 0, 8'h00, 1'b1);
    frame_checks("read_addr");

    bus_start();
    send_byte(8'h78, 1'b1, 1'b0);
    for (int i = 7; i >= 0; i--) send_bit(1'b0, 1'b1);
    m_sda = 1'b1; cyc(HP/2);
    scl   = 1'b1; cyc(3);
    check("ack_before_reset", {31'd0, sda_oe}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("oe_async_reset", {31'd0, sda_oe}, 32'd0);
    cyc(HP);
    scl = 1'b0; cyc(HP);
    scl = 1'b1; cyc(HP);
    rst_n = 1'b1;
    cyc(HP);
    fb = '{8'h78, 8'h00, 8'h8D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    frame(3, 0, 8'h00, 1'b1);
    frame_checks("after_reset");
    check("lit_8d_data", {24'd0, rx_data}, 32'h0000_008D);
    check("lit_8d_dc",   {31'd0, rx_dc},   32'd0);

    cyc(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
